// File: rtl/square_wave_analyzer.sv
// Hysteresis slicer for a sampled square wave: measures period and high time
// in valid-sample units and strobes each completed measurement.
module square_wave_analyzer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned THRESH_HI = 192,
    parameter int unsigned THRESH_LO = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              samp_valid,
    input  logic [DATA_W-1:0] samp,
    output logic              level,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              meas_valid,
    output logic              timeout,
    output logic              locked
);

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    localparam logic [DATA_W-1:0] TH_HI   = DATA_W'(THRESH_HI);
    localparam logic [DATA_W-1:0] TH_LO   = DATA_W'(THRESH_LO);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    state_t            state_q;
    logic              level_q;
    logic [CNT_W-1:0]  per_cnt_q, hi_cnt_q;
    logic [CNT_W-1:0]  period_q, high_time_q;
    logic              meas_valid_q, timeout_q, locked_q;

    logic rise, fall;

    assign rise = samp_valid && !level_q && (samp >= TH_HI);
    assign fall = samp_valid &&  level_q && (samp <= TH_LO);

    // A full per_cnt aborts on any valid sample, including a coincident rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= WAIT_RISE;
            level_q      <= 1'b0;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees the pre-edge state.
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            if (samp_valid) begin
                if (rise)      level_q <= 1'b1;
                else if (fall) level_q <= 1'b0;

                case (state_q)
                    WAIT_RISE: begin
                        if (rise) begin
                            per_cnt_q <= CNT_ONE;
                            hi_cnt_q  <= CNT_ONE;
                            state_q   <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        if (per_cnt_q == CNT_MAX) begin
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                            state_q   <= WAIT_RISE;
                        end else begin
                            per_cnt_q <= per_cnt_q + CNT_ONE;
                            if (fall) state_q  <= MEAS_LOW;
                            else      hi_cnt_q <= hi_cnt_q + CNT_ONE;
                        end
                    end
                    MEAS_LOW: begin
                        if (per_cnt_q == CNT_MAX) begin
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                            state_q   <= WAIT_RISE;
                        end else if (rise) begin
                            period_q     <= per_cnt_q;
                            high_time_q  <= hi_cnt_q;
                            meas_valid_q <= 1'b1;
                            locked_q     <= 1'b1;
                            per_cnt_q    <= CNT_ONE;
                            hi_cnt_q     <= CNT_ONE;
                            state_q      <= MEAS_HIGH;
                        end else begin
                            per_cnt_q <= per_cnt_q + CNT_ONE;
                        end
                    end
                    default: state_q <= WAIT_RISE;
                endcase
            end
        end
    end

    assign level      = level_q;
    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_square_wave_analyzer.sv
// Randomised and directed bench for square_wave_analyzer, checked against a
// sample-index model of rise/fall events (CNT_W overridden to 8 for timeouts).
module tb_square_wave_analyzer;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;
    localparam int TH_HI   = 192;
    localparam int TH_LO   = 64;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              samp_valid = 1'b0;
    logic [DATA_W-1:0] samp = '0;
    logic              level;
    logic [CNT_W-1:0]  period, high_time;
    logic              meas_valid, timeout, locked;

    int checks = 0;
    int failures = 0;

    square_wave_analyzer #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .THRESH_HI(TH_HI), .THRESH_LO(TH_LO)
    ) dut (
        .clk(clk), .rst(rst), .samp_valid(samp_valid), .samp(samp),
        .level(level), .period(period), .high_time(high_time),
        .meas_valid(meas_valid), .timeout(timeout), .locked(locked)
    );

    always #5 clk = ~clk;

    // Model: events are tracked by valid-sample index since reset.
    bit m_level, m_armed, m_mv, m_to, m_locked;
    int m_idx, m_rise_n, m_fall_n, m_period, m_high;
    int n_meas, n_tmo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_armed = 0; m_mv = 0; m_to = 0; m_locked = 0;
        m_idx = 0; m_rise_n = 0; m_fall_n = 0; m_period = 0; m_high = 0;
    endtask

    task automatic model_step(input bit v, input int s);
        bit r, f;
        m_mv = 0;
        m_to = 0;
        if (!v) return;
        r = !m_level && (s >= TH_HI);
        f =  m_level && (s <= TH_LO);
        if (m_armed && (m_idx - m_rise_n) == CNT_MAX) begin
            m_to = 1; m_locked = 0; m_armed = 0; n_tmo++;
        end else if (m_armed && r) begin
            m_period = m_idx - m_rise_n;
            m_high   = m_fall_n - m_rise_n;
            m_mv = 1; m_locked = 1; m_rise_n = m_idx; n_meas++;
        end else if (!m_armed && r) begin
            m_armed = 1; m_rise_n = m_idx;
        end else if (m_armed && f) begin
            m_fall_n = m_idx;
        end
        if (r) m_level = 1;
        else if (f) m_level = 0;
        m_idx++;
    endtask

    task automatic compare_all();
        check("level",      32'(level),      32'(m_level));
        check("meas_valid", 32'(meas_valid), 32'(m_mv));
        check("timeout",    32'(timeout),    32'(m_to));
        check("locked",     32'(locked),     32'(m_locked));
        check("period",     32'(period),     32'(m_period));
        check("high_time",  32'(high_time),  32'(m_high));
    endtask

    task automatic drive(input bit v, input int s);
        samp_valid = v;
        samp = DATA_W'(s);
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else model_step(v, s);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0);
        rst = 1'b1;
    endtask

    // gap: 0 none, 1 one invalid cycle before every valid, 2 random ~25%.
    task automatic run(input int n, input int val, input int gap);
        for (int i = 0; i < n; i++) begin
            if (gap == 1) drive(0, $urandom_range(255));
            else if (gap == 2)
                while ($urandom_range(3) == 0) drive(0, $urandom_range(255));
            drive(1, val);
        end
    endtask

    task automatic run_noisy(input int n, input bit hi);
        int v;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(3) == 0) drive(0, $urandom_range(255));
            v = hi ? $urandom_range(255, TH_HI) : $urandom_range(TH_LO, 0);
            if ($urandom_range(7) == 0) v = $urandom_range(TH_HI - 1, TH_LO + 1);
            drive(1, v);
        end
    endtask

    initial begin
        int meas0;
        model_reset();
        n_meas = 0;
        n_tmo = 0;
        do_reset();
        check("rst_period", 32'(period), 0);
        check("rst_locked", 32'(locked), 0);

        // 64/64 square wave.
        meas0 = n_meas;
        for (int k = 0; k < 4; k++) begin run(64, 8'h00, 0); run(64, 8'hFF, 0); end
        run(1, 8'h00, 0);
        check("t1_nmeas", 32'(n_meas - meas0), 3);
        check("t1_period", 32'(period), 128);
        check("t1_high", 32'(high_time), 64);
        check("t1_locked", 32'(locked), 1);

        // 65 low / 63 high.
        do_reset();
        for (int k = 0; k < 3; k++) begin run(65, 8'h00, 0); run(63, 8'hFF, 0); end
        run(1, 8'h00, 0);
        check("t2_period", 32'(period), 128);
        check("t2_high", 32'(high_time), 63);

        // Same 64/64 stream, samp_valid every other cycle.
        do_reset();
        for (int k = 0; k < 3; k++) begin run(64, 8'h00, 1); run(64, 8'hFF, 1); end
        run(1, 8'h00, 1);
        check("t4_period", 32'(period), 128);
        check("t4_high", 32'(high_time), 64);

        // Mid-band noise inside the high phase does not end it.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run(64, 8'h00, 0); run(30, 8'hFF, 0); run(1, 8'h50, 0); run(33, 8'hFF, 0);
        end
        run(1, 8'h00, 0);
        check("t5_period", 32'(period), 128);
        check("t5_high", 32'(high_time), 64);

        // A low glitch splits the high phase.
        run(63, 8'h00, 0); run(20, 8'hFF, 0); run(1, 8'h20, 0); run(43, 8'hFF, 0);
        check("t5g_period", 32'(period), 21);
        check("t5g_high", 32'(high_time), 20);

        // Lock, then mid-band only: one timeout, period held.
        do_reset();
        run(64, 8'h00, 0); run(64, 8'hFF, 0); run(64, 8'h00, 0); run(64, 8'hFF, 0);
        meas0 = n_tmo;
        for (int k = 0; k < 150; k++) begin run(1, 100, 0); run(1, 150, 0); end
        check("t3_ntmo", 32'(n_tmo - meas0), 1);
        check("t3_locked", 32'(locked), 0);
        check("t3_period", 32'(period), 128);

        // Reset mid MEAS_LOW.
        do_reset();
        run(64, 8'h00, 0); run(64, 8'hFF, 0); run(64, 8'h00, 0); run(64, 8'hFF, 0);
        run(10, 8'h00, 0);
        do_reset();
        check("t6_period", 32'(period), 0);
        check("t6_level", 32'(level), 0);
        meas0 = n_meas;
        run(54, 8'h00, 0); run(64, 8'hFF, 0); run(64, 8'h00, 0);
        check("t6_nomeas", 32'(n_meas - meas0), 0);
        run(1, 8'hFF, 0);
        check("t6_meas", 32'(meas_valid), 1);

        // Random phases, valid gaps, mid-band noise, occasional long phases.
        do_reset();
        for (int k = 0; k < 60; k++) begin
            run_noisy(($urandom_range(9) == 0) ? $urandom_range(300, 200) : $urandom_range(100, 1), 1'b0);
            run_noisy(($urandom_range(9) == 0) ? $urandom_range(300, 200) : $urandom_range(100, 1), 1'b1);
            if ($urandom_range(29) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/square_wave_analyzer.md
Name: square_wave_analyzer

Overview:
Receive-side counterpart to the team's square-wave generator. Takes an 8-bit sampled waveform (ADC or loopback of the generator output) and slices it with a hysteresis comparator. Measures period and high time in sample units, and strobes each completed measurement. Used for loopback self-test and for frequency/duty monitoring.

Parameters:
DATA_W, 8, sample width
CNT_W, 16, width of period/high-time counters and outputs
THRESH_HI, 192, level at or above which a low signal is declared high
THRESH_LO, 64, level at or below which a high signal is declared low (THRESH_LO < THRESH_HI required)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low
samp_valid  input  1  qualifies samp; the block counts only cycles where samp_valid=1
samp  input  DATA_W  unsigned sample
level  output  1  registered hysteresis comparator state
period  output  CNT_W  last measured period, in valid samples
high_time  output  CNT_W  last measured high time, in valid samples
meas_valid  output  1  one-cycle pulse when period/high_time update
timeout  output  1  one-cycle pulse when a measurement is aborted on counter saturation
locked  output  1  high once one measurement is done; cleared by timeout or reset

Behaviour:
- Reset (rst=0 at a clk edge): level=0, period=0, high_time=0, meas_valid=0, timeout=0, locked=0, state=WAIT_RISE, counters=0. Reset takes priority over all other events and aborts any measurement in progress.
- Comparator (only when samp_valid=1):
  - level 0->1 when samp >= THRESH_HI (rise event).
  - level 1->0 when samp <= THRESH_LO (fall event).
  - Otherwise level holds, so values strictly between the thresholds never toggle it.
  - Comparisons are unsigned.
  - Events are evaluated on the incoming sample against the current level register.
- States:
  - WAIT_RISE: ignore everything until a rise event. On rise: hi_cnt=1, per_cnt=1, go to MEAS_HIGH.
  - MEAS_HIGH: each valid sample increments per_cnt. If it is not a fall event, hi_cnt also increments. On a fall event: per_cnt++, hi_cnt frozen, go to MEAS_LOW.
  - MEAS_LOW: each valid non-rise sample increments per_cnt. On a rise event:
    - period <= per_cnt and high_time <= hi_cnt (the rise sample is not included in period).
    - meas_valid=1 for one cycle, locked=1.
    - Restart with hi_cnt=1, per_cnt=1, go to MEAS_HIGH.
- Counting rule: period is the number of valid samples from one rise sample inclusive to the next rise sample exclusive. high_time counts from the rise sample inclusive to the fall sample exclusive. high_time < period always.
- Latency: meas_valid and the updated outputs appear in the cycle after the clk edge that accepts the rise sample (registered outputs).
- samp_valid=0 cycles: no counting and no level change. Outputs hold, except that pulses deassert.
- Saturation: if per_cnt would increment past 2^CNT_W-1 in MEAS_HIGH or MEAS_LOW:
  - timeout=1 for one cycle, locked=0, state=WAIT_RISE.
  - period and high_time hold their last values.
  - level continues to track the input.
  - A rise event on the same sample as saturation is treated as the timeout; the next rise event is needed to re-arm.
- meas_valid and timeout are never asserted in the same cycle.
- A waveform stuck high or stuck low eventually times out (if locked) or stays in WAIT_RISE.

Test Plan:
- Reset, then repeated 64×0x00 / 64×0xFF samples, samp_valid=1 continuously -> first meas_valid after the second rise; period=128, high_time=64, locked=1; pulse repeats every 128 cycles with identical values.
- Pattern 65×0x00, 63×0xFF, 65×0x00, 63×0xFF -> meas_valid every 128 samples; period=128, high_time=63.
- Samples alternating 100/150 after a lock -> level never changes, no meas_valid; with CNT_W=8 override, timeout pulses once when per_cnt reaches 255, locked=0, period unchanged.
- Same 64/64 stream with samp_valid deasserted every other cycle -> period=128, high_time=64 (count in valid samples, not cycles).
- Noisy edge: high phase containing one 0x50 sample (between thresholds) -> no fall event; period=128 unaffected; a single 0x20 sample inside the high phase splits the measurement, giving high_time equal to the samples before the glitch.
- rst=0 asserted mid-MEAS_LOW for one cycle -> next cycle all outputs 0, state WAIT_RISE; first meas_valid only after two further rise events.
